// File: rtl/niosii_system_pio_pkg.sv
// Shared constants for the interrupt-capable PIO: register addresses and the
// edge-detect / interrupt-source encodings used as module parameters.
package niosII_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/niosii_system_pio_irq_sync.sv
// Input synchroniser chain, one-cycle delayed copy (prev) and per-bit edge detect.
// sync_in lags in_port by SYNC_STAGES edges; edge_det is combinational from sync_in/prev.
module niosII_system_pio_sync
    import niosII_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [WIDTH-1:0]                  rise, fall;

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = sync_in;
        rise   = sync_in & ~prev_q;
        fall   = ~sync_in & prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_det = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = rise | fall;
        end else begin
            edge_det = rise;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/niosii_system_pio_irq.sv
// Avalon-MM PIO with direction, sticky edge capture and maskable irq; 1-cycle read latency.
// No backpressure: every access completes in one cycle, readdata refreshes each cycle.
module niosii_system_pio_irq
    import niosII_system_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_TYPE    = IRQ_EDGE,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] sync_in, edge_det, wd, clr;
    logic             wr_en;
    logic             unused_wd;

    // Bits of writedata above WIDTH are intentionally ignored.
    assign unused_wd = ^writedata;

    niosII_system_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    always_comb begin
        wr_en      = chipselect & ~write_n;
        wd         = writedata[WIDTH-1:0];
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmask_d  = irqmask_q;
        clr        = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     dir_d      = wd;
                ADDR_IRQMASK: irqmask_d  = wd;
                default:      clr        = wd;
            endcase
        end
        // A fresh edge wins over a same-cycle clear so no event is dropped.
        edgecap_d = (edgecap_q & ~clr) | edge_det;

        if (IRQ_TYPE == IRQ_LEVEL) begin
            irq_d = |(sync_in & irqmask_q);
        end else begin
            irq_d = |(edgecap_q & irqmask_q);
        end

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = (dir_q & data_out_q) | (~dir_q & sync_in);
            ADDR_DIR:     readdata_d[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            default:      readdata_d[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_OUT;
            dir_q      <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign out_port = data_out_q;
    assign out_oe   = dir_q;
    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_niosii_system_pio_irq.sv
// Bench for the PIO: three configurations share one bus and in_port, each checked
// every cycle against a sample-history reference model plus directed constant checks.
module tb_niosii_system_pio_irq;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [31:0] wdata;
    logic [7:0]  in_port;

    logic [31:0] rd     [3];
    logic [7:0]  op     [3];
    logic [7:0]  oe     [3];
    logic        irq_o  [3];

    int etype [3] = '{0, 2, 1};   // rise, any, fall
    int itype [3] = '{1, 1, 0};   // edge, edge, level

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  m_data, m_dir, m_mask;
    logic [7:0]  m_ecap [3];
    logic [31:0] m_rd   [3];
    logic        m_irq  [3];
    logic [7:0]  hist   [$];

    always #5 clk = ~clk;

    niosii_system_pio_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_TYPE(1), .RESET_OUT(8'hA5)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wr_n),
        .writedata(wdata), .readdata(rd[0]), .in_port(in_port), .out_port(op[0]),
        .out_oe(oe[0]), .irq(irq_o[0]));

    niosii_system_pio_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2), .IRQ_TYPE(1), .RESET_OUT(8'hA5)) u_any (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wr_n),
        .writedata(wdata), .readdata(rd[1]), .in_port(in_port), .out_port(op[1]),
        .out_oe(oe[1]), .irq(irq_o[1]));

    niosii_system_pio_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(1), .IRQ_TYPE(0), .RESET_OUT(8'hA5)) u_lvl (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wr_n),
        .writedata(wdata), .readdata(rd[2]), .in_port(in_port), .out_port(op[2]),
        .out_oe(oe[2]), .irq(irq_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 8'hA5;
        m_dir  = 8'h00;
        m_mask = 8'h00;
        for (int i = 0; i < 3; i++) begin
            m_ecap[i] = 8'h00;
            m_rd[i]   = 32'h0;
            m_irq[i]  = 1'b0;
        end
        hist = {};
        repeat (S + 1) hist.push_back(8'h00);
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out_port%0d", i), {24'h0, op[i]}, {24'h0, m_data});
            chk($sformatf("out_oe%0d", i), {24'h0, oe[i]}, {24'h0, m_dir});
            chk($sformatf("irq%0d", i), {31'h0, irq_o[i]}, {31'h0, m_irq[i]});
            chk($sformatf("readdata%0d", i), rd[i], m_rd[i]);
        end
    endtask

    // One clock: predict from the model's pre-edge view, advance, then compare.
    task automatic tick();
        logic [7:0]  si, pv, e, clr, wd, n_data, n_dir, n_mask;
        logic [7:0]  n_ecap [3];
        logic [31:0] n_rd   [3];
        logic        n_irq  [3];
        logic        wr;
        si  = hist[1];
        pv  = hist[0];
        wr  = cs && !wr_n;
        wd  = wdata[7:0];
        clr = (wr && addr == 2'd3) ? wd : 8'h00;
        n_data = (wr && addr == 2'd0) ? wd : m_data;
        n_dir  = (wr && addr == 2'd1) ? wd : m_dir;
        n_mask = (wr && addr == 2'd2) ? wd : m_mask;
        for (int i = 0; i < 3; i++) begin
            case (etype[i])
                0:       e = si & ~pv;
                1:       e = ~si & pv;
                default: e = si ^ pv;
            endcase
            n_ecap[i] = (m_ecap[i] & ~clr) | e;
            n_irq[i]  = (itype[i] == 0) ? |(si & m_mask) : |(m_ecap[i] & m_mask);
            case (addr)
                2'd0:    n_rd[i] = {24'h0, (m_dir & m_data) | (~m_dir & si)};
                2'd1:    n_rd[i] = {24'h0, m_dir};
                2'd2:    n_rd[i] = {24'h0, m_mask};
                default: n_rd[i] = {24'h0, m_ecap[i]};
            endcase
        end
        @(posedge clk);
        hist.push_back(in_port);
        void'(hist.pop_front());
        m_data = n_data;
        m_dir  = n_dir;
        m_mask = n_mask;
        for (int i = 0; i < 3; i++) begin
            m_ecap[i] = n_ecap[i];
            m_rd[i]   = n_rd[i];
            m_irq[i]  = n_irq[i];
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
        tick();
        cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        addr = a; cs = 1'b1; wr_n = 1'b1;
        tick();
        cs = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; addr = 2'd0; cs = 1'b0; wr_n = 1'b1; wdata = 32'h0; in_port = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_out_port", {24'h0, op[0]}, 32'hA5);
        chk("reset_irq", {31'h0, irq_o[0]}, 32'h0);
        reset_n = 1'b1;
        bus_read(2'd1);
        chk("read_dir_after_reset", rd[0], 32'h0);

        // Mixed direction readback
        bus_write(2'd1, 32'hFFFF_FF0F);
        bus_write(2'd0, 32'h0000_003C);
        in_port = 8'hF0;
        repeat (S + 1) tick();
        bus_read(2'd0);
        chk("data_mixed_dir", rd[0], 32'h0000_00FC);

        // Rising edge on bit0 with edge irq, then W1C clear
        bus_write(2'd2, 32'h01);
        bus_write(2'd3, 32'hFF);
        in_port[0] = 1'b1;
        repeat (S + 1) tick();
        chk("irq_before_edge_latency", {31'h0, irq_o[0]}, 32'h0);
        tick();
        chk("irq_edge_asserted", {31'h0, irq_o[0]}, 32'h1);
        bus_write(2'd3, 32'h01);
        chk("irq_held_at_clear_edge", {31'h0, irq_o[0]}, 32'h1);
        tick();
        chk("irq_after_clear", {31'h0, irq_o[0]}, 32'h0);

        // Edge on bit2 coinciding with its clear
        in_port[2] = 1'b1;
        repeat (S) tick();
        bus_write(2'd3, 32'h04);
        bus_read(2'd3);
        chk("edge_beats_clear", rd[0], 32'h0000_0004);

        // Any-edge capture, masked off
        bus_write(2'd2, 32'h00);
        in_port[1] = 1'b1;
        repeat (5) tick();
        bus_write(2'd3, 32'hFF);
        in_port[1] = 1'b0;
        repeat (5) tick();
        in_port[1] = 1'b1;
        repeat (5) tick();
        bus_read(2'd3);
        chk("any_edge_cap", rd[1], 32'h0000_0002);
        chk("any_edge_irq_masked", {31'h0, irq_o[1]}, 32'h0);

        // Level irq on bit7, then asynchronous reset mid-operation
        in_port[7] = 1'b0;
        repeat (4) tick();
        bus_write(2'd2, 32'h80);
        in_port[7] = 1'b1;
        repeat (S) tick();
        chk("level_irq_not_yet", {31'h0, irq_o[2]}, 32'h0);
        tick();
        chk("level_irq_asserted", {31'h0, irq_o[2]}, 32'h1);
        bus_read(2'd1);
        chk("dir_before_reset", rd[2], 32'h0000_000F);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_irq", {31'h0, irq_o[2]}, 32'h0);
        chk("async_reset_rd", rd[2], 32'h0);
        chk("async_reset_rd_rise", rd[0], 32'h0);
        model_reset();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        bus_read(2'd3);
        chk("edgecap_cleared_by_reset", rd[0], 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            case ($urandom_range(0, 3))
                0: begin cs = 1'b0; wr_n = 1'b1; end
                1: begin cs = 1'b1; wr_n = 1'b0; end
                2: begin cs = 1'b1; wr_n = 1'b1; end
                default: begin cs = 1'b0; wr_n = 1'b0; end
            endcase
            tick();
        end
        cs = 1'b0; wr_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
